reg_op_sequencer: RTL and testbench
===================================

// Module: reg_op_sequencer
// PURPOSE
//  Multi-cycle command sequencer for one general-purpose register. Accepts one
//  command per valid/ready handshake and drives the register's one-hot control
//  lines cl/ld/inc/dec/sr/sl/ir/il. One control pulse per cycle performs
//  N-step increments, decrements, shifts and rotates. Sits between the CPU
//  control unit and a datapath register.
// PARAMETERS
//  DATA_WIDTH  16  register width; width of cmd_data, reg_in, reg_out
//  CNT_WIDTH   4   step-count width; max steps = 2**CNT_WIDTH-1
// PORTS
//  clk        in   1           clock; all state updates on rising edge
//  rst        in   1           reset, synchronous, active-high
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           sequencer can accept a command
//  cmd_op     in   3           0 CLR,1 LOAD,2 INC,3 DEC,4 SHR,5 SHL,6 ROR,7 ROL
//  cmd_cnt    in   CNT_WIDTH   step count (ignored by CLR/LOAD)
//  cmd_data   in   DATA_WIDTH  LOAD value
//  cmd_fill   in   1           serial fill bit for SHR/SHL
//  abort      in   1           stop the running command
//  reg_out    in   DATA_WIDTH  current register value (rotate feedback)
//  reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  out 1  register controls
//  reg_ir, reg_il  out  1      serial-in bits for sr/sl
//  reg_in     out  DATA_WIDTH  load data (latched cmd_data)
//  busy       out  1           state != IDLE
//  done       out  1           one-cycle completion pulse
//  err        out  1           valid only with done; 1 = aborted or unsupported op
// BEHAVIOUR
//  - Reset: state IDLE. All reg_* controls 0, reg_in 0, done 0, err 0, busy 0.
//    cmd_ready is 1 on the first cycle after reset is released.
//  - FSM IDLE -> RUN -> DONE -> IDLE. cmd_ready = (state==IDLE).
//  - IDLE: on cmd_valid&&cmd_ready, latch op/cnt/data/fill.
//    Remaining steps: CLR/LOAD = 1, others = cmd_cnt.
//    If remaining steps == 0 (cnt 0 or unsupported op), go to DONE. Else go to RUN.
//  - RUN: exactly one control line is high per cycle, as a combinational decode
//    of the latched op. No line is high outside RUN.
//    CLR:cl  LOAD:ld  INC:inc  DEC:dec  SHR:sr,ir=fill  SHL:sl,il=fill
//    ROR:sr,ir=reg_out[0]  ROL:sl,il=reg_out[DATA_WIDTH-1]
//    The step counter decrements each RUN cycle. When the count reaches 1, go to DONE.
//  - Timing: accept at edge T; pulses in cycles T+1..T+N; done=1 in cycle T+N+1;
//    cmd_ready=1 again in T+N+2. cnt=0: done in T+1, no pulses.
//  - abort in RUN: all controls are forced 0 in that same cycle. Go to DONE
//    with err=1. The partial result stays in the register.
//  - abort in IDLE or DONE: ignored. abort has no effect on a command being accepted.
//  - Counts do not wrap; the maximum is 2**CNT_WIDTH-1 pulses.
//    Arithmetic overflow is the register's concern (16'hFFFF + 1 = 0).
//  - cmd_* are sampled only at acceptance. Later changes do not affect the
//    running command.
//  - rst mid-RUN: controls are 0 from the next edge. No done pulse. State is IDLE.
// CONFIGURATION
//  REG_SEQ_ROTATE_EN defined: ops 6/7 rotate as above.
//  REG_SEQ_ROTATE_EN undefined: ops 6/7 are accepted but issue no pulses;
//    done=1 with err=1 in T+1. No reg_out feedback logic is built.
// TESTING
//  1 reset, then LOAD 16'h1234 -> single ld pulse with reg_in=16'h1234; done in T+2;
//    err=0; register=16'h1234.
//  2 INC cnt=5 from 16'hFFFE -> 5 inc pulses in consecutive cycles; register=16'h0003;
//    done at T+6.
//  3 SHL cnt=3 fill=1 from 16'h0001 -> 3 sl pulses with il=1; register=16'h000F.
//  4 ROR cnt=4 from 16'h000F -> register=16'hF000 (EN defined). With EN undefined:
//    no pulses, done+err at T+1, register unchanged.
//  5 DEC cnt=15, abort at 3rd pulse cycle -> only 2 dec pulses land; done+err next
//    cycle; register = start-2.
//  6 cnt=0 INC -> no pulses, done at T+1. Back-to-back valid held high -> second
//    command accepted only when cmd_ready=1 (T+2). rst asserted mid-SHR -> no further
//    pulses, no done.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: multi-step one-hot control sequencer for a datapath register; define REG_SEQ_ROTATE_EN to enable ops 6/7 as rotates
module reg_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_fill,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] reg_out,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state;
  logic [2:0]           op;
  logic [CNT_WIDTH-1:0] cnt, steps;
  logic                 fill, err_q, fire, unsup;
  assign fire      = state == RUN && !abort;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign err       = done && err_q;
  assign reg_cl    = fire && op == 3'd0;
  assign reg_ld    = fire && op == 3'd1;
  assign reg_inc   = fire && op == 3'd2;
  assign reg_dec   = fire && op == 3'd3;
  assign steps     = unsup ? '0 : (cmd_op[2:1] == 2'b00 ? CNT_WIDTH'(1) : cmd_cnt);
`ifdef REG_SEQ_ROTATE_EN
  assign unsup  = 1'b0;
  assign reg_sr = fire && (op == 3'd4 || op == 3'd6);
  assign reg_sl = fire && (op == 3'd5 || op == 3'd7);
  assign reg_ir = reg_sr && (op[1] ? reg_out[0] : fill);
  assign reg_il = reg_sl && (op[1] ? reg_out[DATA_WIDTH-1] : fill);
`else
  logic unused_reg_out;
  assign unused_reg_out = ^reg_out;
  assign unsup  = cmd_op[2] && cmd_op[1];
  assign reg_sr = fire && op == 3'd4;
  assign reg_sl = fire && op == 3'd5;
  assign reg_ir = reg_sr && fill;
  assign reg_il = reg_sl && fill;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      err_q  <= 1'b0;
      reg_in <= '0;
    end else
      case (state)
        IDLE:
          if (cmd_valid) begin
            op     <= cmd_op;
            cnt    <= steps;
            fill   <= cmd_fill;
            reg_in <= cmd_data;
            err_q  <= unsup;
            state  <= steps == '0 ? DONE : RUN;
          end
        RUN: begin
          cnt   <= cnt - 1'b1;
          err_q <= abort;
          if (abort || cnt == CNT_WIDTH'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer: directed self-checking bench for reg_op_sequencer with a behavioural register
module tb_reg_op_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_cnt = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_fill = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] r;
  logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il;
  logic [15:0] reg_in;
  logic        busy, done, err;
  int          checks = 0;
  int          passed = 0;
  int          n_cl, n_ld, n_inc, n_dec, n_sr, n_sl, ir_ones, il_ones, multi, ld_ok, done_cyc;
  logic        err_seen;
  reg_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .abort(abort), .reg_out(r),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_ir(reg_ir), .reg_il(reg_il),
    .reg_in(reg_in), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    r <= reg_cl ? 16'h0000 : reg_ld ? reg_in : reg_inc ? r + 16'd1 : reg_dec ? r - 16'd1 :
         reg_sr ? {reg_ir, r[15:1]} : reg_sl ? {r[14:0], reg_il} : r;
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [15:0] data,
                         input logic fill, input int abort_at);
    {n_cl, n_ld, n_inc, n_dec, n_sr, n_sl, ir_ones, il_ones, multi, ld_ok, done_cyc} = '0;
    err_seen = 1'b0;
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_cnt = ~cnt; cmd_data = ~data; cmd_fill = ~fill;
    for (int k = 1; k <= 40 && done_cyc == 0; k++) begin
      abort = (k == abort_at);
      #1;
      if ($countones({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}) > 1) multi++;
      if (reg_cl) n_cl++;
      if (reg_ld) begin n_ld++; if (reg_in === data) ld_ok++; end
      if (reg_inc) n_inc++;
      if (reg_dec) n_dec++;
      if (reg_sr) begin n_sr++; if (reg_ir) ir_ones++; end
      if (reg_sl) begin n_sl++; if (reg_il) il_ones++; end
      if (done) begin done_cyc = k; err_seen = err; end
      @(posedge clk); #1;
    end
    abort = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if ({done, err} !== 2'b00) $display("FAIL reset_done_err got %b want 00", {done, err}); else passed++;
    checks++; if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il} !== 8'h00)
      $display("FAIL reset_controls got %b want 0", {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il}); else passed++;
    checks++; if (reg_in !== 16'h0000) $display("FAIL reset_reg_in got %h want 0000", reg_in); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_load;
    run_cmd(3'd1, 4'd7, 16'h1234, 1'b0, 0);
    checks++; if (n_ld !== 1 || ld_ok !== 1) $display("FAIL load_pulse got %0d/%0d want 1/1", n_ld, ld_ok); else passed++;
    checks++; if (n_cl + n_inc + n_dec + n_sr + n_sl !== 0) $display("FAIL load_other_pulses got %0d want 0", n_cl + n_inc + n_dec + n_sr + n_sl); else passed++;
    checks++; if (done_cyc !== 2) $display("FAIL load_done_cycle got %0d want 2", done_cyc); else passed++;
    checks++; if (err_seen !== 1'b0) $display("FAIL load_err got %b want 0", err_seen); else passed++;
    checks++; if (r !== 16'h1234) $display("FAIL load_reg got %h want 1234", r); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL load_ready_after got %b want 1", cmd_ready); else passed++;
    run_cmd(3'd0, 4'd3, 16'h0000, 1'b0, 0);
    checks++; if (n_cl !== 1 || r !== 16'h0000) $display("FAIL clr got %0d pulses reg %h want 1 pulse reg 0000", n_cl, r); else passed++;
  endtask
  task automatic test_inc;
    run_cmd(3'd1, 4'd0, 16'hFFFE, 1'b0, 0);
    run_cmd(3'd2, 4'd5, 16'h0000, 1'b0, 0);
    checks++; if (n_inc !== 5) $display("FAIL inc_pulses got %0d want 5", n_inc); else passed++;
    checks++; if (done_cyc !== 6) $display("FAIL inc_done_cycle got %0d want 6", done_cyc); else passed++;
    checks++; if (r !== 16'h0003) $display("FAIL inc_reg got %h want 0003", r); else passed++;
    checks++; if (multi !== 0) $display("FAIL inc_onehot got %0d multi-cycles want 0", multi); else passed++;
  endtask
  task automatic test_shift;
    run_cmd(3'd1, 4'd0, 16'h0001, 1'b0, 0);
    run_cmd(3'd5, 4'd3, 16'h0000, 1'b1, 0);
    checks++; if (n_sl !== 3 || il_ones !== 3) $display("FAIL shl_pulses got %0d il=%0d want 3/3", n_sl, il_ones); else passed++;
    checks++; if (r !== 16'h000F) $display("FAIL shl_reg got %h want 000F", r); else passed++;
    checks++; if (done_cyc !== 4) $display("FAIL shl_done_cycle got %0d want 4", done_cyc); else passed++;
    run_cmd(3'd4, 4'd2, 16'h0000, 1'b0, 0);
    checks++; if (n_sr !== 2 || ir_ones !== 0 || r !== 16'h0003) $display("FAIL shr_fill0 got %0d/%0d reg %h want 2/0 reg 0003", n_sr, ir_ones, r); else passed++;
  endtask
  task automatic test_rotate;
    run_cmd(3'd1, 4'd0, 16'h000F, 1'b0, 0);
    run_cmd(3'd6, 4'd4, 16'h0000, 1'b0, 0);
`ifdef REG_SEQ_ROTATE_EN
    checks++; if (n_sr !== 4 || ir_ones !== 4) $display("FAIL ror_pulses got %0d ir=%0d want 4/4", n_sr, ir_ones); else passed++;
    checks++; if (r !== 16'hF000) $display("FAIL ror_reg got %h want F000", r); else passed++;
    checks++; if (done_cyc !== 5 || err_seen !== 1'b0) $display("FAIL ror_done got %0d err %b want 5 err 0", done_cyc, err_seen); else passed++;
    run_cmd(3'd1, 4'd0, 16'h8001, 1'b0, 0);
    run_cmd(3'd7, 4'd1, 16'h0000, 1'b0, 0);
    checks++; if (n_sl !== 1 || il_ones !== 1 || r !== 16'h0003) $display("FAIL rol got %0d/%0d reg %h want 1/1 reg 0003", n_sl, il_ones, r); else passed++;
`else
    checks++; if (n_sr + n_sl !== 0) $display("FAIL ror_disabled_pulses got %0d want 0", n_sr + n_sl); else passed++;
    checks++; if (done_cyc !== 1 || err_seen !== 1'b1) $display("FAIL ror_disabled_done got %0d err %b want 1 err 1", done_cyc, err_seen); else passed++;
    checks++; if (r !== 16'h000F) $display("FAIL ror_disabled_reg got %h want 000F", r); else passed++;
`endif
  endtask
  task automatic test_abort;
    run_cmd(3'd1, 4'd0, 16'h0100, 1'b0, 0);
    run_cmd(3'd3, 4'd15, 16'h0000, 1'b0, 3);
    checks++; if (n_dec !== 2) $display("FAIL abort_pulses got %0d want 2", n_dec); else passed++;
    checks++; if (done_cyc !== 4 || err_seen !== 1'b1) $display("FAIL abort_done got %0d err %b want 4 err 1", done_cyc, err_seen); else passed++;
    checks++; if (r !== 16'h00FE) $display("FAIL abort_reg got %h want 00FE", r); else passed++;
    abort = 1'b1;
    run_cmd(3'd2, 4'd1, 16'h0000, 1'b0, 0);
    checks++; if (n_inc !== 1 || err_seen !== 1'b0 || r !== 16'h00FF) $display("FAIL abort_idle got %0d err %b reg %h want 1 err 0 reg 00FF", n_inc, err_seen, r); else passed++;
  endtask
  task automatic test_counts;
    run_cmd(3'd2, 4'd0, 16'h0000, 1'b0, 0);
    checks++; if (n_inc !== 0 || done_cyc !== 1 || err_seen !== 1'b0) $display("FAIL cnt0 got %0d pulses done %0d err %b want 0/1/0", n_inc, done_cyc, err_seen); else passed++;
    run_cmd(3'd1, 4'd0, 16'h0000, 1'b0, 0);
    run_cmd(3'd2, 4'd15, 16'h0000, 1'b0, 0);
    checks++; if (n_inc !== 15 || done_cyc !== 16 || r !== 16'h000F) $display("FAIL cnt_max got %0d done %0d reg %h want 15/16/000F", n_inc, done_cyc, r); else passed++;
  endtask
  task automatic test_back_to_back;
    logic [5:0] inc_pat, rdy_pat;
    run_cmd(3'd1, 4'd0, 16'h0000, 1'b0, 0);
    cmd_op = 3'd2; cmd_cnt = 4'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      #1;
      inc_pat[k] = reg_inc;
      rdy_pat[k] = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    #1;
    checks++; if (inc_pat !== 6'b110011) $display("FAIL b2b_inc_pattern got %b want 110011", inc_pat); else passed++;
    checks++; if (rdy_pat !== 6'b001000) $display("FAIL b2b_ready_pattern got %b want 001000", rdy_pat); else passed++;
    checks++; if (done !== 1'b1) $display("FAIL b2b_second_done got %b want 1", done); else passed++;
    @(posedge clk); #1;
    checks++; if (r !== 16'h0004) $display("FAIL b2b_reg got %h want 0004", r); else passed++;
  endtask
  task automatic test_reset_mid_run;
    int pulses, stray, dones;
    run_cmd(3'd1, 4'd0, 16'h0000, 1'b0, 0);
    cmd_op = 3'd4; cmd_cnt = 4'd10; cmd_fill = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pulses = 0; stray = 0; dones = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      if (reg_sr) pulses++;
      if (k == 3) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if ({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il} != 8'h00 || busy) stray++;
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++; if (pulses !== 3 || r !== 16'hE000) $display("FAIL rst_mid_pre got %0d reg %h want 3 reg E000", pulses, r); else passed++;
    checks++; if (stray !== 0 || dones !== 0) $display("FAIL rst_mid_after got stray %0d done %0d want 0/0", stray, dones); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", cmd_ready); else passed++;
  endtask
  initial begin
    test_reset;
    test_load;
    test_inc;
    test_shift;
    test_rotate;
    test_abort;
    test_counts;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
